// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core: captures decode results,
// inserts one bubble per load-use hazard, and honours downstream stall and flush.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      id_valid,
    input  logic [6:0]                id_op,
    input  logic [2:0]                id_funct3,
    input  logic [6:0]                id_funct7,
    input  logic [DATA_WIDTH-1:0]     id_pc,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic                      id_reg_write,
    input  logic                      id_jump,
    input  logic                      id_branch,
    input  logic                      ex_stall,
    input  logic                      ex_flush,
    output logic                      ex_valid,
    output logic [6:0]                ex_op,
    output logic [2:0]                ex_funct3,
    output logic [6:0]                ex_funct7,
    output logic [DATA_WIDTH-1:0]     ex_pc,
    output logic [DATA_WIDTH-1:0]     ex_rs1_data,
    output logic [DATA_WIDTH-1:0]     ex_rs2_data,
    output logic [DATA_WIDTH-1:0]     ex_imm,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs1,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs2,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic                      ex_reg_write,
    output logic                      ex_jump,
    output logic                      ex_branch,
    output logic                      load_use_stall,
    output logic [CNT_WIDTH-1:0]      bubble_count
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic uses_rs1;
    logic uses_rs2;
    logic load_data;

    assign uses_rs1 = !((id_op == OP_LUI) || (id_op == OP_AUIPC) || (id_op == OP_JAL));
    assign uses_rs2 = (id_op == OP_RTYPE) || (id_op == OP_STORE) || (id_op == OP_BRANCH);

    // x0 as a load destination never creates a dependency
    assign load_use_stall = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                            ((uses_rs1 & (ex_rd == id_rs1)) | (uses_rs2 & (ex_rd == id_rs2)));

    // A flush still captures the decode fields; only valid and control are killed
    assign load_data = ex_flush | (!ex_stall & !load_use_stall);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_jump      <= 1'b0;
            ex_branch    <= 1'b0;
            bubble_count <= '0;
        end else if (ex_flush) begin
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_jump      <= 1'b0;
            ex_branch    <= 1'b0;
        end else if (ex_stall) begin
            ex_valid     <= ex_valid;
        end else if (load_use_stall) begin
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_jump      <= 1'b0;
            ex_branch    <= 1'b0;
            if (bubble_count != '1)
                bubble_count <= bubble_count + CNT_ONE;
        end else begin
            ex_valid     <= id_valid;
            ex_mem_read  <= id_mem_read  & id_valid;
            ex_mem_write <= id_mem_write & id_valid;
            ex_reg_write <= id_reg_write & id_valid;
            ex_jump      <= id_jump      & id_valid;
            ex_branch    <= id_branch    & id_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_op       <= '0;
            ex_funct3   <= '0;
            ex_funct7   <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
        end else if (load_data) begin
            ex_op       <= id_op;
            ex_funct3   <= id_funct3;
            ex_funct7   <= id_funct7;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage; a second instance with a 4-bit
// bubble counter shares the stimulus to exercise saturation.
`timescale 1ns/1ps
module tb_id_ex_stage;

    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct {
        logic        valid;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, pc;
        logic [4:0]  ctrl;
        logic        stall, flush;
        logic        exp_lus;
        logic        exp_valid;
        logic [4:0]  exp_ctrl;
        int          exp_src;
        int          exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        id_valid, id_mem_read, id_mem_write, id_reg_write, id_jump, id_branch;
    logic [6:0]  id_op, id_funct7;
    logic [2:0]  id_funct3;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        ex_stall, ex_flush;

    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_jump, ex_branch, load_use_stall;
    logic [6:0]  ex_op, ex_funct7;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [15:0] bubble_count;

    logic        s_valid, s_mem_read, s_mem_write, s_reg_write, s_jump, s_branch, s_lus;
    logic [6:0]  s_op, s_funct7;
    logic [2:0]  s_funct3;
    logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [3:0]  s_count;

    id_ex_stage dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_op(id_op),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .id_jump(id_jump), .id_branch(id_branch), .ex_stall(ex_stall), .ex_flush(ex_flush),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_jump(ex_jump), .ex_branch(ex_branch), .load_use_stall(load_use_stall),
        .bubble_count(bubble_count)
    );

    id_ex_stage #(.CNT_WIDTH(4)) dut_small (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_op(id_op),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .id_jump(id_jump), .id_branch(id_branch), .ex_stall(ex_stall), .ex_flush(ex_flush),
        .ex_valid(s_valid), .ex_op(s_op), .ex_funct3(s_funct3), .ex_funct7(s_funct7),
        .ex_pc(s_pc), .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data), .ex_imm(s_imm),
        .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
        .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write), .ex_reg_write(s_reg_write),
        .ex_jump(s_jump), .ex_branch(s_branch), .load_use_stall(s_lus),
        .bubble_count(s_count)
    );

    logic [159:0] main_data, small_data;
    assign main_data  = {ex_op, ex_funct3, ex_funct7, ex_pc, ex_rs1_data, ex_rs2_data,
                         ex_imm, ex_rs1, ex_rs2, ex_rd};
    assign small_data = {s_op, s_funct3, s_funct7, s_pc, s_rs1_data, s_rs2_data,
                         s_imm, s_rs1, s_rs2, s_rd};

    int vec_count = 0;
    int err_count = 0;
    vec_t vecs[16];

    function automatic vec_t mk(logic v, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                logic [4:0] rs2, logic [31:0] imm, logic [31:0] pc,
                                logic [4:0] ctrl, logic st, logic fl, logic el, logic ev,
                                logic [4:0] ec, int src, int cnt);
        vec_t r;
        r.valid = v; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.pc = pc;
        r.ctrl = ctrl; r.stall = st; r.flush = fl; r.exp_lus = el; r.exp_valid = ev;
        r.exp_ctrl = ec; r.exp_src = src; r.exp_cnt = cnt;
        return r;
    endfunction

    // Operand data and funct fields are derived from pc so every vector is distinct
    function automatic logic [159:0] expData(vec_t s);
        return {s.op, s.pc[4:2], s.pc[9:3], s.pc, s.pc ^ 32'hA5A5_0000, ~s.pc,
                s.imm, s.rs1, s.rs2, s.rd};
    endfunction

    task automatic applyStimulus(vec_t v);
        id_valid    = v.valid;
        id_op       = v.op;
        id_funct3   = v.pc[4:2];
        id_funct7   = v.pc[9:3];
        id_pc       = v.pc;
        id_rs1_data = v.pc ^ 32'hA5A5_0000;
        id_rs2_data = ~v.pc;
        id_imm      = v.imm;
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        id_rd       = v.rd;
        {id_mem_read, id_mem_write, id_reg_write, id_jump, id_branch} = v.ctrl;
        ex_stall    = v.stall;
        ex_flush    = v.flush;
    endtask

    task automatic checkOutput(string name, logic [159:0] act, logic [159:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkLus(string tag, logic exp);
        checkOutput({tag, " load_use_stall"}, 160'(load_use_stall), 160'(exp));
        checkOutput({tag, " small load_use_stall"}, 160'(s_lus), 160'(exp));
    endtask

    task automatic checkState(string tag, vec_t src, logic ev, logic [4:0] ec, int cnt, int scnt);
        checkOutput({tag, " ex_valid"}, 160'(ex_valid), 160'(ev));
        checkOutput({tag, " ex_ctrl"},
                    160'({ex_mem_read, ex_mem_write, ex_reg_write, ex_jump, ex_branch}), 160'(ec));
        checkOutput({tag, " ex_data"}, main_data, expData(src));
        checkOutput({tag, " bubble_count"}, 160'(bubble_count), 160'(cnt));
        checkOutput({tag, " small ex_valid"}, 160'(s_valid), 160'(ev));
        checkOutput({tag, " small ex_ctrl"},
                    160'({s_mem_read, s_mem_write, s_reg_write, s_jump, s_branch}), 160'(ec));
        checkOutput({tag, " small ex_data"}, small_data, expData(src));
        checkOutput({tag, " small bubble_count"}, 160'(s_count), 160'(scnt));
    endtask

    task automatic checkZero(string tag);
        checkOutput({tag, " ex_valid"}, 160'(ex_valid), 160'(0));
        checkOutput({tag, " ex_ctrl"},
                    160'({ex_mem_read, ex_mem_write, ex_reg_write, ex_jump, ex_branch}), 160'(0));
        checkOutput({tag, " ex_data"}, main_data, 160'(0));
        checkOutput({tag, " bubble_count"}, 160'(bubble_count), 160'(0));
        checkOutput({tag, " small ex_data"}, small_data, 160'(0));
        checkOutput({tag, " small bubble_count"}, 160'(s_count), 160'(0));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t lw, add;
        // ctrl order: {mem_read, mem_write, reg_write, jump, branch}
        vecs[0]  = mk(1, OP_ADDI,   5, 1, 0, 32'h10,       32'h100, 5'b00100, 0, 0, 0, 1, 5'b00100, 0, 0);
        vecs[1]  = mk(1, OP_LOAD,   3, 2, 0, 32'h4,        32'h104, 5'b10100, 0, 0, 0, 1, 5'b10100, 1, 0);
        vecs[2]  = mk(1, OP_RTYPE,  4, 1, 3, 32'h0,        32'h108, 5'b00100, 0, 0, 1, 0, 5'b00000, 1, 1);
        vecs[3]  = mk(1, OP_RTYPE,  4, 1, 3, 32'h0,        32'h108, 5'b00100, 0, 0, 0, 1, 5'b00100, 3, 1);
        vecs[4]  = mk(1, OP_LOAD,   0, 2, 0, 32'h8,        32'h10C, 5'b10100, 0, 0, 0, 1, 5'b10100, 4, 1);
        vecs[5]  = mk(1, OP_RTYPE,  6, 0, 0, 32'h0,        32'h110, 5'b00100, 0, 0, 0, 1, 5'b00100, 5, 1);
        vecs[6]  = mk(1, OP_LOAD,   3, 1, 0, 32'hC,        32'h114, 5'b10100, 0, 0, 0, 1, 5'b10100, 6, 1);
        vecs[7]  = mk(1, OP_LUI,    7, 3, 3, 32'h12345000, 32'h118, 5'b00100, 0, 0, 0, 1, 5'b00100, 7, 1);
        vecs[8]  = mk(1, OP_LOAD,   3, 1, 0, 32'h10,       32'h11C, 5'b10100, 0, 0, 0, 1, 5'b10100, 8, 1);
        vecs[9]  = mk(1, OP_STORE,  0, 3, 9, 32'h20,       32'h120, 5'b01000, 1, 1, 1, 0, 5'b00000, 9, 1);
        vecs[10] = mk(0, OP_STORE,  0, 0, 0, 32'h30,       32'h124, 5'b01000, 0, 0, 0, 0, 5'b00000, 10, 1);
        vecs[11] = mk(1, OP_LOAD,   8, 1, 0, 32'h4,        32'h128, 5'b10100, 0, 0, 0, 1, 5'b10100, 11, 1);
        vecs[12] = mk(1, OP_JAL,    1, 8, 8, 32'h40,       32'h12C, 5'b00110, 0, 0, 0, 1, 5'b00110, 12, 1);
        vecs[13] = mk(1, OP_LOAD,   9, 1, 0, 32'h0,        32'h130, 5'b10100, 0, 0, 0, 1, 5'b10100, 13, 1);
        vecs[14] = mk(1, OP_BRANCH, 0, 1, 9, 32'h80,       32'h134, 5'b00001, 0, 0, 1, 0, 5'b00000, 13, 2);
        vecs[15] = mk(1, OP_BRANCH, 0, 1, 9, 32'h80,       32'h134, 5'b00001, 0, 0, 0, 1, 5'b00001, 15, 2);

        reset_n = 1'b0;
        applyStimulus(vecs[0]);
        @(posedge clk); #1;
        checkZero("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkLus($sformatf("v%0d", i), vecs[i].exp_lus);
            @(posedge clk); #1;
            checkState($sformatf("v%0d", i), vecs[vecs[i].exp_src], vecs[i].exp_valid,
                       vecs[i].exp_ctrl, vecs[i].exp_cnt, vecs[i].exp_cnt);
        end

        // Hazard pending while the execute side is stalled for three cycles
        lw  = mk(1, OP_LOAD,  10, 1,  0, 32'h14, 32'h140, 5'b10100, 0, 0, 0, 0, 5'b0, 0, 0);
        add = mk(1, OP_RTYPE, 11, 10, 2, 32'h0,  32'h144, 5'b00100, 1, 0, 0, 0, 5'b0, 0, 0);
        applyStimulus(lw);
        @(posedge clk); #1;
        checkState("stall lw", lw, 1, 5'b10100, 2, 2);
        applyStimulus(add);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkLus($sformatf("stall%0d", k), 1'b1);
            @(posedge clk); #1;
            checkState($sformatf("stall%0d", k), lw, 1, 5'b10100, 2, 2);
        end
        add.stall = 1'b0;
        applyStimulus(add);
        #1;
        checkLus("unstall", 1'b1);
        @(posedge clk); #1;
        checkState("unstall bubble", lw, 0, 5'b00000, 3, 3);
        checkLus("unstall after bubble", 1'b0);
        @(posedge clk); #1;
        checkState("unstall add", add, 1, 5'b00100, 3, 3);

        // Seventeen more hazards saturate the 4-bit counter
        for (int h = 0; h < 17; h++) begin
            applyStimulus(lw);
            @(posedge clk); #1;
            applyStimulus(add);
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        checkState("saturate", add, 1, 5'b00100, 20, 15);
        applyStimulus(lw);
        @(posedge clk); #1;
        applyStimulus(add);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkState("saturate hold", add, 1, 5'b00100, 21, 15);

        // Asynchronous reset between edges with a valid instruction in ex
        applyStimulus(vecs[3]);
        @(posedge clk); #1;
        checkState("pre-reset", vecs[3], 1, 5'b00100, 21, 15);
        #2;
        reset_n = 1'b0;
        #1;
        checkZero("async reset");
        @(posedge clk); #1;
        checkZero("reset held");
        reset_n = 1'b1;
        applyStimulus(vecs[0]);
        @(posedge clk); #1;
        checkState("post-reset", vecs[0], 1, 5'b00100, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
